// File: rtl/alu_arbiter_if.sv
// Request/response/ALU-side signal bundle for alu_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding logic's view.
interface alu_arbiter_if;
    logic        i_flush;

    logic        i_req0_valid;
    logic        o_req0_ready;
    logic [2:0]  i_req0_op_mode;
    logic [2:0]  i_req0_func_op;
    logic [31:0] i_req0_a;
    logic [31:0] i_req0_b;

    logic        i_req1_valid;
    logic        o_req1_ready;
    logic [2:0]  i_req1_op_mode;
    logic [2:0]  i_req1_func_op;
    logic [31:0] i_req1_a;
    logic [31:0] i_req1_b;

    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic        o_rsp_id;
    logic [31:0] o_rsp_result;

    logic [2:0]  o_alu_op_mode;
    logic [2:0]  o_alu_func_op;
    logic [31:0] o_alu_a;
    logic [31:0] o_alu_b;
    logic        o_alu_stall;
    logic        i_alu_stall;
    logic [31:0] i_alu_result;

    modport slave (
        input  i_flush,
        input  i_req0_valid, i_req0_op_mode, i_req0_func_op, i_req0_a, i_req0_b,
        output o_req0_ready,
        input  i_req1_valid, i_req1_op_mode, i_req1_func_op, i_req1_a, i_req1_b,
        output o_req1_ready,
        output o_rsp_valid, o_rsp_id, o_rsp_result,
        input  i_rsp_ready,
        output o_alu_op_mode, o_alu_func_op, o_alu_a, o_alu_b, o_alu_stall,
        input  i_alu_stall, i_alu_result
    );

    modport master (
        output i_flush,
        output i_req0_valid, i_req0_op_mode, i_req0_func_op, i_req0_a, i_req0_b,
        input  o_req0_ready,
        output i_req1_valid, i_req1_op_mode, i_req1_func_op, i_req1_a, i_req1_b,
        input  o_req1_ready,
        input  o_rsp_valid, o_rsp_id, o_rsp_result,
        output i_rsp_ready,
        input  o_alu_op_mode, o_alu_func_op, o_alu_a, o_alu_b, o_alu_stall,
        output i_alu_stall, i_alu_result
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters, sequencing each request
// (including multi-cycle mul/div) and returning the registered result with its requester id.
//
// state     | meaning
// ----------+----------------------------------------------------------------
// ST_IDLE   | ALU parked (mode IDLE, stalled); ready to accept a request
// ST_EXEC   | hold registers drive the ALU unstalled until it drops o_stall
// ST_RESP   | ALU result register frozen and presented on the response channel
module alu_arbiter (
    input  logic         i_clk,
    input  logic         i_rst_n,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_rr;
    logic        r_id;
    logic [2:0]  r_op_mode;
    logic [2:0]  r_func_op;
    logic [31:0] r_a;
    logic [31:0] r_b;

    logic        w_rr_valid;
    logic        w_other_valid;
    logic        w_grant;
    logic        w_any_valid;
    logic        w_can_accept;
    logic        w_accept;
    logic        w_rsp_done;

    // Priority port wins if valid; otherwise the other port, if it is valid.
    assign w_rr_valid    = r_rr ? bus.i_req1_valid : bus.i_req0_valid;
    assign w_other_valid = r_rr ? bus.i_req0_valid : bus.i_req1_valid;
    assign w_grant       = (~w_rr_valid & w_other_valid) ? ~r_rr : r_rr;
    assign w_any_valid   = bus.i_req0_valid | bus.i_req1_valid;

    assign w_rsp_done    = (r_state == ST_RESP) & bus.i_rsp_ready;
    assign w_can_accept  = ~bus.i_flush & ((r_state == ST_IDLE) | w_rsp_done);
    assign w_accept      = w_can_accept & w_any_valid;

    assign bus.o_req0_ready = w_can_accept & ~w_grant;
    assign bus.o_req1_ready = w_can_accept & w_grant;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (bus.i_flush) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) w_next_state = ST_EXEC;
                end
                ST_EXEC: begin
                    if (!bus.i_alu_stall) w_next_state = ST_RESP;
                end
                ST_RESP: begin
                    if (bus.i_rsp_ready) w_next_state = w_accept ? ST_EXEC : ST_IDLE;
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr      <= 1'b0;
            r_id      <= 1'b0;
            r_op_mode <= 3'd0;
            r_func_op <= 3'd0;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
        end else if (w_accept) begin
            r_rr      <= ~w_grant;
            r_id      <= w_grant;
            r_op_mode <= w_grant ? bus.i_req1_op_mode : bus.i_req0_op_mode;
            r_func_op <= w_grant ? bus.i_req1_func_op : bus.i_req0_func_op;
            r_a       <= w_grant ? bus.i_req1_a       : bus.i_req0_a;
            r_b       <= w_grant ? bus.i_req1_b       : bus.i_req0_b;
        end
    end

    // Outside EXEC the ALU sees IDLE and a stall, freezing its result and re-arming mul/div.
    always_comb begin
        bus.o_alu_op_mode = 3'd0;
        bus.o_alu_func_op = 3'd0;
        bus.o_alu_a       = 32'd0;
        bus.o_alu_b       = 32'd0;
        bus.o_alu_stall   = 1'b1;
        if (r_state == ST_EXEC) begin
            bus.o_alu_op_mode = r_op_mode;
            bus.o_alu_func_op = r_func_op;
            bus.o_alu_a       = r_a;
            bus.o_alu_b       = r_b;
            bus.o_alu_stall   = 1'b0;
        end
    end

    assign bus.o_rsp_valid  = (r_state == ST_RESP);
    assign bus.o_rsp_id     = r_id;
    assign bus.o_rsp_result = bus.i_alu_result;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU (registered result,
// mul 3 cycles / div 5 cycles of o_stall handshake) attached to the ALU port.
module tb_alu_arbiter;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alu_arbiter_if bus();

    alu_arbiter dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural ALU
    logic [31:0] alu_res;
    logic [2:0]  alu_cnt;
    logic        alu_md;
    logic [2:0]  alu_lat;

    assign alu_md  = (bus.o_alu_op_mode == 3'd5) || (bus.o_alu_op_mode == 3'd6);
    assign alu_lat = (bus.o_alu_op_mode == 3'd5) ? 3'd2 : 3'd4;
    assign bus.i_alu_stall  = alu_md && !bus.o_alu_stall && (alu_cnt < alu_lat);
    assign bus.i_alu_result = alu_res;

    function automatic logic [31:0] alu_f(input logic [2:0] m, input logic [2:0] f,
                                          input logic [31:0] a, input logic [31:0] b);
        case (m)
            3'd1:    alu_f = (f == 3'd1) ? (a | b) : (f == 3'd2) ? (a ^ b) : (a & b);
            3'd4:    alu_f = f[0] ? (a - b) : (a + b);
            3'd5:    alu_f = a * b;
            3'd6:    alu_f = (b == 32'd0) ? 32'hFFFF_FFFF : (a / b);
            default: alu_f = a;
        endcase
    endfunction

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            alu_cnt <= 3'd0;
            alu_res <= 32'd0;
        end else begin
            if (!alu_md || bus.o_alu_stall) alu_cnt <= 3'd0;
            else                            alu_cnt <= alu_cnt + 3'd1;
            if (!bus.o_alu_stall && !bus.i_alu_stall)
                alu_res <= alu_f(bus.o_alu_op_mode, bus.o_alu_func_op, bus.o_alu_a, bus.o_alu_b);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic set_req(input int p, input logic v, input logic [2:0] m, input logic [2:0] f,
                           input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin
            bus.i_req0_valid = v; bus.i_req0_op_mode = m; bus.i_req0_func_op = f;
            bus.i_req0_a = a;     bus.i_req0_b = b;
        end else begin
            bus.i_req1_valid = v; bus.i_req1_op_mode = m; bus.i_req1_func_op = f;
            bus.i_req1_a = a;     bus.i_req1_b = b;
        end
    endtask

    bit eid;

    initial begin
        bus.i_flush = 1'b0;
        bus.i_rsp_ready = 1'b0;
        set_req(0, 1'b0, 3'd0, 3'd0, 32'd0, 32'd0);
        set_req(1, 1'b0, 3'd0, 3'd0, 32'd0, 32'd0);

        // Reset values
        #1;
        chk("rst_rsp_valid", bus.o_rsp_valid, 0);
        chk("rst_rsp_id", bus.o_rsp_id, 0);
        chk("rst_rsp_result", bus.o_rsp_result, 0);
        chk("rst_alu_mode", bus.o_alu_op_mode, 0);
        chk("rst_alu_func", bus.o_alu_func_op, 0);
        chk("rst_alu_a", bus.o_alu_a, 0);
        chk("rst_alu_b", bus.o_alu_b, 0);
        chk("rst_alu_stall", bus.o_alu_stall, 1);
        bus.i_req1_valid = 1'b1;
        #1;
        chk("rst_rdy0_other", bus.o_req0_ready, 0);
        chk("rst_rdy1_other", bus.o_req1_ready, 1);
        bus.i_req1_valid = 1'b0;
        bus.i_req0_valid = 1'b1;
        #1;
        chk("rst_rdy0", bus.o_req0_ready, 1);
        chk("rst_rdy1", bus.o_req1_ready, 0);
        bus.i_req0_valid = 1'b0;
        #8 i_rst_n = 1'b1;
        tick();

        // Single add on port 0: 5 + 7
        bus.i_rsp_ready = 1'b1;
        set_req(0, 1'b1, 3'd4, 3'd0, 32'd5, 32'd7);
        #1;
        chk("add_rdy0", bus.o_req0_ready, 1);
        tick();
        bus.i_req0_valid = 1'b0;
        #1;
        chk("add_exec_mode", bus.o_alu_op_mode, 4);
        chk("add_exec_a", bus.o_alu_a, 5);
        chk("add_exec_b", bus.o_alu_b, 7);
        chk("add_exec_stall", bus.o_alu_stall, 0);
        chk("add_exec_rsp", bus.o_rsp_valid, 0);
        tick();
        chk("add_rsp_valid", bus.o_rsp_valid, 1);
        chk("add_rsp_result", bus.o_rsp_result, 12);
        chk("add_rsp_id", bus.o_rsp_id, 0);
        chk("add_rsp_alu_mode", bus.o_alu_op_mode, 0);
        chk("add_rsp_alu_stall", bus.o_alu_stall, 1);
        tick();
        chk("add_idle_rsp", bus.o_rsp_valid, 0);

        // Multi-cycle mul on port 1: 6 * 7
        set_req(1, 1'b1, 3'd5, 3'd0, 32'd6, 32'd7);
        #1;
        chk("mul_rdy1", bus.o_req1_ready, 1);
        chk("mul_rdy0", bus.o_req0_ready, 0);
        tick();
        bus.i_req1_valid = 1'b0;
        set_req(0, 1'b1, 3'd4, 3'd0, 32'd1, 32'd1);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("mul_exec_mode", bus.o_alu_op_mode, 5);
            chk("mul_exec_a", bus.o_alu_a, 6);
            chk("mul_exec_b", bus.o_alu_b, 7);
            chk("mul_exec_rdy0", bus.o_req0_ready, 0);
            chk("mul_exec_rdy1", bus.o_req1_ready, 0);
            chk("mul_exec_rsp", bus.o_rsp_valid, 0);
            tick();
        end
        bus.i_req0_valid = 1'b0;
        #1;
        chk("mul_rsp_valid", bus.o_rsp_valid, 1);
        chk("mul_rsp_result", bus.o_rsp_result, 42);
        chk("mul_rsp_id", bus.o_rsp_id, 1);
        tick();

        // Contention: port 0 does 10-3, port 1 does 0xF0^0x0F
        set_req(0, 1'b1, 3'd4, 3'd1, 32'd10, 32'd3);
        set_req(1, 1'b1, 3'd1, 3'd2, 32'h0F0, 32'h00F);
        for (int n = 0; n < 4; n++) begin
            eid = n[0];
            #1;
            chk("cont_rdy0", bus.o_req0_ready, {31'd0, ~eid});
            chk("cont_rdy1", bus.o_req1_ready, {31'd0, eid});
            tick();
            chk("cont_exec_mode", bus.o_alu_op_mode, eid ? 32'd1 : 32'd4);
            tick();
            chk("cont_rsp_valid", bus.o_rsp_valid, 1);
            chk("cont_rsp_id", bus.o_rsp_id, {31'd0, eid});
            chk("cont_rsp_result", bus.o_rsp_result, eid ? 32'hFF : 32'd7);
        end
        bus.i_req0_valid = 1'b0;
        bus.i_req1_valid = 1'b0;
        tick();
        chk("cont_idle_rsp", bus.o_rsp_valid, 0);

        // Backpressure: port 0 add 2+3, held 5 cycles; port 1 mode 7 waits behind it
        bus.i_rsp_ready = 1'b0;
        set_req(0, 1'b1, 3'd4, 3'd0, 32'd2, 32'd3);
        tick();
        tick();
        set_req(1, 1'b1, 3'd7, 3'd0, 32'h1234, 32'h55);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", bus.o_rsp_valid, 1);
            chk("bp_rsp_result", bus.o_rsp_result, 5);
            chk("bp_alu_stall", bus.o_alu_stall, 1);
            chk("bp_rdy0", bus.o_req0_ready, 0);
            chk("bp_rdy1", bus.o_req1_ready, 0);
            tick();
        end
        bus.i_rsp_ready = 1'b1;
        #1;
        chk("bp_release_rdy1", bus.o_req1_ready, 1);
        chk("bp_release_rdy0", bus.o_req0_ready, 0);
        tick();
        bus.i_req0_valid = 1'b0;
        bus.i_req1_valid = 1'b0;
        #1;
        chk("op7_exec_mode", bus.o_alu_op_mode, 7);
        chk("op7_exec_a", bus.o_alu_a, 32'h1234);
        tick();
        chk("op7_rsp_valid", bus.o_rsp_valid, 1);
        chk("op7_rsp_result", bus.o_rsp_result, 32'h1234);
        chk("op7_rsp_id", bus.o_rsp_id, 1);
        tick();

        // Flush in the 3rd EXEC cycle of 100/7
        set_req(0, 1'b1, 3'd6, 3'd0, 32'd100, 32'd7);
        tick();
        bus.i_req0_valid = 1'b0;
        tick();
        tick();
        bus.i_flush = 1'b1;
        #1;
        chk("flush_exec_mode", bus.o_alu_op_mode, 6);
        chk("flush_rdy0", bus.o_req0_ready, 0);
        tick();
        bus.i_flush = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("flush_rsp_valid", bus.o_rsp_valid, 0);
            chk("flush_alu_mode", bus.o_alu_op_mode, 0);
            chk("flush_alu_stall", bus.o_alu_stall, 1);
            tick();
        end
        chk("flush_rr_kept", dut.r_rr, 1);
        set_req(0, 1'b1, 3'd6, 3'd0, 32'd100, 32'd7);
        #1;
        chk("div_rdy0", bus.o_req0_ready, 1);
        tick();
        bus.i_req0_valid = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("div_exec_mode", bus.o_alu_op_mode, 6);
            chk("div_exec_rsp", bus.o_rsp_valid, 0);
            tick();
        end
        chk("div_rsp_valid", bus.o_rsp_valid, 1);
        chk("div_rsp_result", bus.o_rsp_result, 14);
        chk("div_rsp_id", bus.o_rsp_id, 0);
        tick();

        // Reset during EXEC of 3*4 on port 0
        set_req(0, 1'b1, 3'd5, 3'd0, 32'd3, 32'd4);
        tick();
        bus.i_req0_valid = 1'b0;
        #1;
        chk("rmul_exec_mode", bus.o_alu_op_mode, 5);
        i_rst_n = 1'b0;
        #1;
        chk("rmul_alu_mode", bus.o_alu_op_mode, 0);
        chk("rmul_alu_a", bus.o_alu_a, 0);
        chk("rmul_alu_b", bus.o_alu_b, 0);
        chk("rmul_alu_stall", bus.o_alu_stall, 1);
        chk("rmul_rsp_valid", bus.o_rsp_valid, 0);
        chk("rmul_rr", dut.r_rr, 0);
        #1 i_rst_n = 1'b1;
        tick();
        chk("rmul_no_rsp", bus.o_rsp_valid, 0);
        set_req(0, 1'b1, 3'd4, 3'd0, 32'd1, 32'd1);
        #1;
        chk("radd_rdy0", bus.o_req0_ready, 1);
        tick();
        bus.i_req0_valid = 1'b0;
        #1;
        chk("radd_exec_mode", bus.o_alu_op_mode, 4);
        chk("radd_exec_rsp", bus.o_rsp_valid, 0);
        tick();
        chk("radd_rsp_valid", bus.o_rsp_valid, 1);
        chk("radd_rsp_result", bus.o_rsp_result, 2);
        chk("radd_rsp_id", bus.o_rsp_id, 0);
        tick();
        chk("radd_idle", bus.o_rsp_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single `alu` instance between two requesters (port 0: integer issue pipe, port 1: branch/address unit). It uses valid/ready handshakes and round-robin arbitration. Each request is sequenced through the ALU, including multi-cycle INT_MUL/INT_DIV, by holding operands and mode until the ALU drops `o_stall`. The registered ALU result is returned with the requester ID on a single valid/ready response channel.

## Interface
- No parameters; data width fixed at 32, op_mode/func_op at 3 bits (ALU encoding: 0 IDLE, 1 LOGIC, 2 SHIFT, 3 COMPARE, 4 INT_ADD_SUB, 5 INT_MUL, 6 INT_DIV).
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_flush  in  1  synchronous abort of the in-flight request; its response is dropped
- i_req0_valid / i_req1_valid  in  1  request present on port n
- o_req0_ready / o_req1_ready  out  1  port n request accepted this cycle when valid&ready
- i_reqN_op_mode  in  3  requested operation mode, port N
- i_reqN_func_op  in  3  functional option, port N
- i_reqN_a / i_reqN_b  in  32  operands, port N
- o_rsp_valid  out  1  response available
- i_rsp_ready  in  1  consumer accepts response
- o_rsp_id  out  1  requester of current response
- o_rsp_result  out  32  result
- o_alu_op_mode  out  3  to ALU i_op_mode
- o_alu_func_op  out  3  to ALU i_func_op
- o_alu_a / o_alu_b  out  32  to ALU operands
- o_alu_stall  out  1  to ALU i_stall (1 = hold ALU result register)
- i_alu_stall  in  1  from ALU o_stall
- i_alu_result  in  32  from ALU o_result

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Hold registers capture the granted op_mode, func_op, a, b and id on acceptance. ALU outputs are driven from the hold registers only in EXEC.
- Outside EXEC: `o_alu_op_mode`=0 (IDLE), `o_alu_func_op`=0, `o_alu_a`=`o_alu_b`=0, `o_alu_stall`=1. This keeps the ALU result register stable and lets mul/div valid-detect re-arm.
- In EXEC: `o_alu_stall`=0.
- Arbitration:
  - Pointer `rr` (reset 0) names the priority port.
  - Grant goes to `rr` if valid, else to the other port if valid.
  - After every accepted request, `rr` = ~granted id.
- `o_reqN_ready` = can_accept & (grant==N), where can_accept = (state==IDLE) | (state==RESP & i_rsp_ready & ~i_flush).
- Transitions:
  - IDLE → EXEC on acceptance.
  - EXEC → RESP when `i_alu_stall`=0; the ALU captures its result at that edge.
  - EXEC stays in EXEC while `i_alu_stall`=1, with operands held constant.
  - RESP → EXEC if a new request is accepted in the same cycle as the response handshake.
  - RESP → IDLE on response handshake with no new acceptance.
  - RESP stays in RESP while `i_rsp_ready`=0.
- In RESP: `o_rsp_valid`=1, `o_rsp_result`=`i_alu_result`, `o_rsp_id`=hold id. Result is stable because `o_alu_stall`=1.
- op_mode 7 is passed through unchanged; the ALU returns operand a, and the response is still generated.
- i_flush:
  - In any state, forces next state IDLE, `o_rsp_valid` low next cycle, and `o_reqN_ready`=0 that cycle. `rr` is unchanged.
  - Flush in EXEC drives ALU mode IDLE the next cycle, abandoning any mul/div.
  - Flush has priority over acceptance and response.
- Reset mid-operation: all state is cleared immediately. Outputs take their IDLE values and `rr`=0. No response is produced for the aborted request.

## Timing
- Reset values:
  - `o_rsp_valid`=0, `o_rsp_id`=0, `o_rsp_result`=ALU result (0 after ALU reset).
  - `o_alu_op_mode`=0, `o_alu_func_op`=0, `o_alu_a`=`o_alu_b`=0, `o_alu_stall`=1.
  - `o_reqN_ready`: granted port high if its valid is high.
- Single-cycle op latency:
  - Accept at edge k.
  - EXEC during cycle k..k+1.
  - `o_rsp_valid` high in the cycle after edge k+1 (2 cycles accept-to-response).
- Multi-cycle op: EXEC lasts until the first cycle with `i_alu_stall`=0. The response appears the cycle after that.
- Back-to-back throughput: one request per 2 cycles when `i_rsp_ready` is held high (accept in RESP).
- `o_reqN_ready` is combinational from valids, state, `i_rsp_ready` and `i_flush`. All other outputs are registered or decoded from state and hold registers only.

## Test plan
- Single add, port 0: op_mode 4, func_op 0, a=5, b=7. Require ALU driven with these values for exactly 1 cycle, then `o_rsp_valid`=1, result=12, id=0, 2 cycles after acceptance.
- Contention: both ports valid continuously with subtract 10-3 (port 0) and XOR 0xF0^0x0F (port 1), `i_rsp_ready`=1. Require grants in order 0,1,0,1 and results 7, 0xFF, 7, 0xFF with ids alternating.
- Multi-cycle mul: 6*7 on port 1. Require operands held constant while `i_alu_stall`=1, response 42 with id=1 one cycle after stall drops, and no ready asserted during EXEC.
- Backpressure: `i_rsp_ready`=0 for 5 cycles in RESP. Require result stable, `o_alu_stall`=1, both readies 0. When ready rises, require a new request accepted in the same cycle.
- Flush mid-div: 100/7, flush in 3rd EXEC cycle. Require no response and state IDLE. Then a subsequent div 100/7 returns 14.
- Reset asserted during EXEC of a mul. Require immediate IDLE outputs and `rr`=0. After release, a new add 1+1 returns 2 with normal 2-cycle latency.
